// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adapter
// Purpose  : Bridges a cache's single-cycle line interface to a 4-beat burst
//            memory bus. A 256-bit line write is split into four 64-bit beats.
//            Four 64-bit read beats are reassembled into one 256-bit line.
//            Completion is signalled back to the cache with a one-cycle
//            resp_o pulse.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            line_i       - write-back line from the cache
//            line_o       - assembled fill line to the cache
//            address_i    - line address from the cache
//            read_i       - line read request
//            write_i      - line write request
//            resp_o       - line transfer complete (one-cycle pulse)
//            burst_i      - read beat from memory
//            burst_o      - write beat to memory
//            address_o    - line-aligned burst base address to memory
//            read_o       - burst read request
//            write_o      - burst write request
//            resp_i       - beat accepted/valid from memory
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
    parameter int S_LINE    = 256,
    parameter int S_BURST   = 64,
    parameter int NUM_BEATS = S_LINE / S_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_LINE-1:0]    line_i,
    output logic [S_LINE-1:0]    line_o,
    input  logic [31:0]          address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    output logic                 resp_o,
    input  logic [S_BURST-1:0]   burst_i,
    output logic [S_BURST-1:0]   burst_o,
    output logic [31:0]          address_o,
    output logic                 read_o,
    output logic                 write_o,
    input  logic                 resp_i
);

    localparam int                 C_CNT_W     = $clog2(NUM_BEATS);
    localparam logic [C_CNT_W-1:0] C_LAST_BEAT = C_CNT_W'(NUM_BEATS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    // Clears the byte-offset-within-line bits so memory always sees a
    // line-aligned base address.
    localparam logic [31:0]        C_ADDR_MASK = ~32'(S_LINE / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [C_CNT_W-1:0]   r_count;
    logic [31:0]          r_addr;
    logic [S_LINE-1:0]    r_wline;
    logic [31:0]          w_base_addr;
    logic                 w_last_beat;

    assign w_base_addr = r_addr & C_ADDR_MASK;
    assign w_last_beat = resp_i && (r_count == C_LAST_BEAT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode. All bus outputs are pure functions of
    // the registered state, so an asynchronous reset clears them at once.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;
        address_o    = '0;
        burst_o      = '0;

        case (r_state)
            ST_IDLE: begin
                // Write wins so a dirty victim is evicted before the fill.
                if (write_i) begin
                    w_next_state = ST_WRITE;
                end else if (read_i) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                read_o    = 1'b1;
                address_o = w_base_addr;
                if (w_last_beat) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_WRITE: begin
                write_o   = 1'b1;
                address_o = w_base_addr;
                burst_o   = r_wline[r_count*S_BURST +: S_BURST];
                if (w_last_beat) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // Always return to IDLE so a request still held high here is
                // not accepted twice back to back.
                resp_o       = 1'b1;
                address_o    = w_base_addr;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, beat counter and line reassembly.
    // The counter naturally wraps to 0 on the final beat, which is the
    // transition into DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            line_o  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (write_i) begin
                        r_addr  <= address_i;
                        r_wline <= line_i;
                        r_count <= '0;
                    end else if (read_i) begin
                        r_addr  <= address_i;
                        r_count <= '0;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        line_o[r_count*S_BURST +: S_BURST] <= burst_i;
                        r_count <= r_count + C_CNT_ONE;
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        r_count <= r_count + C_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
